mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
// PURPOSE
//  Upstream stimulus/capture stage for the 3-input mux/decoder datapath.
//  Walks the select code {A,B,C} through all 8 values, holds each for DWELL cycles,
//  samples the returned Y0 on the last dwell cycle, and packs the 8 samples into a
//  truth-table word. Hands the word off downstream over a VALID/READY handshake.
// PARAMETERS
//  DWELL   4   cycles each code is held (>=1); Y0 sampled on the last one
// PORTS
//  CLK     in   1  single clock; all state updates on posedge
//  RST     in   1  synchronous, active-high reset
//  START   in   1  request a scan; accepted only in IDLE
//  A       out  1  select code bit 2 (MSB), to mux input A
//  B       out  1  select code bit 1, to mux input B
//  C       out  1  select code bit 0 (LSB), to mux input C
//  Y0      in   1  mux output for the currently driven code
//  RESULT  out  8  captured truth table; RESULT[k] = Y0 sampled while {A,B,C}==k
//  VALID   out  1  RESULT complete and stable
//  READY   in   1  downstream accepts RESULT
//  BUSY    out  1  high in DRIVE and DONE
// BEHAVIOUR
//  Reset (RST high at posedge): state=IDLE, A=B=C=0, RESULT=8'h00, VALID=0, BUSY=0,
//   dwell counter=0. Applies from any state, including mid-scan; partial results discarded.
//  States: IDLE, DRIVE, DONE. All outputs registered.
//  IDLE: START=1 -> DRIVE; code<=0, cnt<=DWELL-1, RESULT<=8'h00. START=0 -> stay.
//  DRIVE: code held on {A,B,C}; cnt decrements each cycle.
//   cnt==0: RESULT[code]<=Y0; if code==7 -> DONE (VALID<=1), else code<=code+1, cnt<=DWELL-1.
//   START ignored in DRIVE and DONE (no restart, no queueing).
//  DONE: VALID=1, RESULT and {A,B,C}=3'b111 held until READY=1 -> IDLE, VALID<=0,
//   code<=0. VALID never drops without READY. READY while VALID=0 has no effect.
//  Timing: START high at edge t -> code 0 visible from t+1; code k driven for cycles
//   t+1+k*DWELL .. t+(k+1)*DWELL; VALID first high at cycle t+1+8*DWELL.
//  DWELL=1: one cycle per code, sample every cycle; 8-cycle scan.
//  Y0 treated as combinational from {A,B,C}; no synchroniser. Code wrap 7->0 only via DONE/IDLE.
//  Back-to-back: START high in the same cycle DONE->IDLE exits is ignored (accepted from IDLE only).
// STRUCTURE
//  Shared include mux_defs.vh: state encodings (ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_DONE=2'd2),
//   NCODES=8, CODE_W=3.
//  One sub-module: dwell_timer (load/decrement/zero-flag, width $clog2(DWELL)+1).
//  Top holds FSM, code register, RESULT shift/index logic, handshake.
// TESTING (bench instantiates the existing mux, Y0 = A ? C : B, DWELL=4)
//  1 Reset: RST=1 two cycles -> A,B,C=0, RESULT=8'h00, VALID=0, BUSY=0.
//  2 Full scan: START pulse, READY=0 -> VALID at t+33, RESULT=8'hAC; check codes 0..7 each 4 cycles.
//  3 Hold: keep READY=0 20 cycles -> VALID=1, RESULT=8'hAC, {A,B,C}=3'b111 stable; READY=1 -> VALID=0 next cycle, IDLE.
//  4 START ignored: pulse START at code 3 mid-scan -> scan unaffected, VALID still at t+33.
//  5 Reset mid-scan: RST at code 5 -> all outputs reset values next cycle; new START -> full scan, 8'hAC.
//  6 DWELL=1 instance: START -> VALID at t+9, RESULT=8'hAC; Y0 tied 1 -> RESULT=8'hFF.

Source files
------------

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer: code space size and FSM state encoding.
package mux_scan_sequencer_pkg;

    localparam int NCODES = 8;
    localparam int CODE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_sequencer_dwell_timer.sv
// Dwell countdown: loadable down-counter with a zero flag taken straight from the register.
module dwell_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans select code {A,B,C} through 0..7, captures Y0 on the last dwell cycle of each code,
// and offers the packed truth table downstream over VALID/READY.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    output logic       A,
    output logic       B,
    output logic       C,
    input  logic       Y0,
    output logic [7:0] RESULT,
    output logic       VALID,
    input  logic       READY,
    output logic       BUSY
);

    localparam int CNT_W = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);
    localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(NCODES - 1);

    state_t            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [7:0]        result_q, result_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    logic timer_load;
    logic timer_dec;
    logic timer_zero;

    dwell_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (timer_load),
        .dec      (timer_dec),
        .load_val (RELOAD),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        result_d   = result_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d    = ST_DRIVE;
                    code_d     = '0;
                    result_d   = 8'h00;
                    busy_d     = 1'b1;
                    timer_load = 1'b1;
                end
            end
            ST_DRIVE: begin
                // Timer at zero marks the last dwell cycle of the current code.
                if (timer_zero) begin
                    result_d[code_q] = Y0;
                    if (code_q == LAST_CODE) begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                    end else begin
                        code_d     = code_q + CODE_W'(1);
                        timer_load = 1'b1;
                    end
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_DONE: begin
                if (READY) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    code_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            code_q   <= '0;
            result_q <= 8'h00;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign A      = code_q[2];
    assign B      = code_q[1];
    assign C      = code_q[0];
    assign RESULT = result_q;
    assign VALID  = valid_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: DWELL=4 and DWELL=1 instances driving a modelled 2:1 mux,
// compared every cycle against an arithmetic scan model.
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b0;
    logic tie1 = 1'b0;

    logic a4, b4, c4, valid4, busy4;
    logic a1, b1, c1, valid1, busy1;
    logic [7:0] res4, res1;
    logic y0_4, y0_1;

    int total = 0;
    int bad = 0;

    // Per-instance model: mode 0 idle, 1 scanning, 2 holding result
    int         m_mode [2] = '{0, 0};
    int         m_n    [2] = '{0, 0};
    logic [7:0] m_res  [2] = '{8'h00, 8'h00};
    int         dw     [2] = '{4, 1};

    always #5 clk = ~clk;

    assign y0_4 = a4 ? c4 : b4;
    assign y0_1 = tie1 ? 1'b1 : (a1 ? c1 : b1);

    mux_scan_sequencer #(.DWELL(4)) dut4 (
        .CLK(clk), .RST(rst), .START(start), .A(a4), .B(b4), .C(c4), .Y0(y0_4),
        .RESULT(res4), .VALID(valid4), .READY(ready), .BUSY(busy4)
    );

    mux_scan_sequencer #(.DWELL(1)) dut1 (
        .CLK(clk), .RST(rst), .START(start), .A(a1), .B(b1), .C(c1), .Y0(y0_1),
        .RESULT(res1), .VALID(valid1), .READY(ready), .BUSY(busy1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fullTable(input int i);
        logic [7:0] t;
        logic [2:0] k3;
        t = 8'h00;
        for (int k = 0; k < 8; k++) begin
            k3 = k[2:0];
            t[k] = (i == 1 && tie1) ? 1'b1 : (k3[2] ? k3[0] : k3[1]);
        end
        return t;
    endfunction

    task automatic modelStep();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mode[i] = 0;
                m_n[i] = 0;
                m_res[i] = 8'h00;
            end else begin
                case (m_mode[i])
                    0: if (start) begin
                        m_mode[i] = 1;
                        m_n[i] = 0;
                    end
                    1: begin
                        m_n[i]++;
                        if (m_n[i] == 8 * dw[i]) m_mode[i] = 2;
                    end
                    default: if (ready) begin
                        m_mode[i] = 0;
                        m_res[i] = fullTable(i);
                    end
                endcase
            end
        end
    endtask

    task automatic compareAll();
        int s;
        logic [7:0] mask;
        logic [2:0] exp_code;
        logic [7:0] exp_res;
        for (int i = 0; i < 2; i++) begin
            s = m_n[i] / dw[i];
            mask = 8'((32'd1 << s) - 1);
            exp_code = (m_mode[i] == 1) ? 3'(s) : (m_mode[i] == 2) ? 3'd7 : 3'd0;
            exp_res = (m_mode[i] == 0) ? m_res[i] : (fullTable(i) & mask);
            checkOutput($sformatf("d%0d code", dw[i]),
                        (i == 0) ? {a4, b4, c4} : {a1, b1, c1}, exp_code);
            checkOutput($sformatf("d%0d result", dw[i]), (i == 0) ? res4 : res1, exp_res);
            checkOutput($sformatf("d%0d valid", dw[i]), (i == 0) ? valid4 : valid1, m_mode[i] == 2);
            checkOutput($sformatf("d%0d busy", dw[i]), (i == 0) ? busy4 : busy1, m_mode[i] != 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    // Issues a one-cycle START, then runs until dut4 raises VALID, recording both latencies
    task automatic applyStimulus(input int mid_start_at, output int lat4, output int lat1);
        int lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        lat4 = 0;
        lat1 = 0;
        while (lat4 == 0 && lat < 100) begin
            start = (lat == mid_start_at);
            tick();
            start = 1'b0;
            lat++;
            if (valid1 && lat1 == 0) lat1 = lat;
            if (valid4) lat4 = lat;
        end
    endtask

    initial begin
        int l4, l1;

        rst = 1'b1;
        tick();
        tick();
        checkOutput("reset code", {a4, b4, c4}, 3'd0);
        checkOutput("reset result", res4, 8'h00);
        checkOutput("reset valid/busy", {valid4, busy4}, 2'b00);
        rst = 1'b0;
        tick();

        applyStimulus(-1, l4, l1);
        checkOutput("latency d4", l4, 33);
        checkOutput("latency d1", l1, 9);
        checkOutput("scan d4", res4, 8'hAC);
        checkOutput("scan d1", res1, 8'hAC);

        repeat (20) tick();
        checkOutput("hold valid", valid4, 1'b1);
        checkOutput("hold result", res4, 8'hAC);
        checkOutput("hold code", {a4, b4, c4}, 3'b111);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checkOutput("release valid", valid4, 1'b0);
        checkOutput("release busy", busy4, 1'b0);
        tick();

        applyStimulus(13, l4, l1);
        checkOutput("mid start latency", l4, 33);
        checkOutput("mid start result", res4, 8'hAC);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        checkOutput("code before reset", {a4, b4, c4}, 3'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midreset code", {a4, b4, c4}, 3'd0);
        checkOutput("midreset result", res4, 8'h00);
        checkOutput("midreset valid/busy", {valid4, busy4}, 2'b00);
        applyStimulus(-1, l4, l1);
        checkOutput("rescan latency", l4, 33);
        checkOutput("rescan result", res4, 8'hAC);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        tie1 = 1'b1;
        applyStimulus(-1, l4, l1);
        checkOutput("tied d1 latency", l1, 9);
        checkOutput("tied d1 result", res1, 8'hFF);
        checkOutput("untied d4 result", res4, 8'hAC);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tie1 = 1'b0;

        for (int phase = 0; phase < 4; phase++) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            tie1 = 1'($urandom_range(0, 1));
            repeat (250) begin
                start = ($urandom_range(0, 5) == 0);
                ready = ($urandom_range(0, 3) == 0);
                rst   = ($urandom_range(0, 149) == 0);
                tick();
            end
            start = 1'b0;
            ready = 1'b0;
            rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
